// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Package : mac_pkg
// Brief   : Shared widths and FSM state encoding for the mac_accum block.
// Rev     : 1.0  initial release
// ============================================================================
package mac_pkg;

  localparam int MAC_N      = 8;
  localparam int MAC_ACC_W  = 20;
  localparam int MAC_CNT_W  = 8;
  localparam int MAC_PROD_W = 2 * MAC_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/mult8.sv
`default_nettype none
// ============================================================================
// Module  : mult8
// Brief   : Combinational unsigned N x N array multiplier (shift-and-add rows).
// Rev     : 1.0  initial release
// ============================================================================
module mult8 #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_prod
);

  localparam int PW = 2 * N;

  logic [PW-1:0] w_acc;

  // Sum one shifted copy of A per set bit of B
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N; i++) begin
      if (i_b[i]) begin
        w_acc = w_acc + (PW'(i_a) << i);
      end
    end
  end

  assign o_prod = w_acc;

endmodule
`default_nettype wire

// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// Module  : mac_accum
// Brief   : Packet multiply-accumulate front end around mult8. Operand pairs
//           enter over valid/ready, pass S1 (operand regs) -> mult8 -> S2
//           (product reg) -> S3 (accumulator); the packet sum is offered on a
//           valid/ready output once the last beat has been added.
// Config  : MAC_SAT_EN - when defined the accumulator saturates at all-ones on
//           overflow; otherwise it wraps. ovf is sticky in both builds.
// Rev     : 1.0  initial release
// ============================================================================
module mac_accum
  import mac_pkg::*;
#(
  parameter int N     = MAC_N,
  parameter int ACC_W = MAC_ACC_W,
  parameter int CNT_W = MAC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             ovf
);

  localparam int PW = 2 * N;

  mac_state_t       r_state;
  mac_state_t       w_state_nxt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_done_hs;

  // S1 operand stage
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_last1;
  logic             r_v1;

  // S2 product stage
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    r_prod;
  logic             r_last2;
  logic             r_v2;

  // S3 accumulator
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_beat_cnt;

  assign w_accept  = in_valid && w_in_ready;
  assign w_done_hs = (r_state == ST_DONE) && out_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: packet closes on the last accept, result ready once the
  // last product has been added
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = in_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && in_last) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_v2 && r_last2) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only while a packet is open, offer the sum in DONE
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE:  w_in_ready  = 1'b1;
      ST_RUN:   w_in_ready  = 1'b1;
      ST_DONE:  w_out_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // S1: capture operands on accept; valid marks only freshly accepted beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_last1 <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_last1 <= in_last;
      end
    end
  end

  mult8 #(
    .N (N)
  ) u_mult8 (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_prod (w_prod)
  );

  // S2: product stage loads every cycle; the pipeline never stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_last2 <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_prod  <= w_prod;
      r_last2 <= r_last1;
      r_v2    <= r_v1;
    end
  end

  // One extra bit captures the carry-out used for overflow detection
  assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(r_prod);
  assign w_carry = w_sum[ACC_W];

`ifdef MAC_SAT_EN
  // Once saturated the accumulator is pinned at all-ones for the packet
  assign w_acc_nxt = (w_carry || r_ovf) ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  // S3: accumulate valid products; the output handshake starts a new packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_done_hs) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_v2) begin
      r_acc <= w_acc_nxt;
      if (w_carry) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Beat counter: counts accepts, wraps naturally, clears with the packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_done_hs) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign acc_out   = r_acc;
  assign beat_cnt  = r_beat_cnt;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_accum
// Brief   : Directed self-checking bench for mac_accum.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mac_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] acc_out;
  logic [7:0]  beat_cnt;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  mac_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .beat_cnt  (beat_cnt),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] exp17;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef MAC_SAT_EN
    exp17 = 32'd1048575;
`else
    exp17 = 32'd56849;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc",       acc_out,   0);
    chk("rst_beat",      beat_cnt,  0);
    chk("rst_ovf",       ovf,       0);
    rst = 1'b0;
    tick();

    // Single beat 3 x 5: result two edges after the accept
    send(8'd3, 8'd5, 1'b1);
    chk("t1_in_ready_k",  in_ready,  0);
    chk("t1_valid_k",     out_valid, 0);
    tick();
    chk("t1_valid_k1",    out_valid, 0);
    tick();
    chk("t1_valid_k2",    out_valid, 1);
    chk("t1_acc",         acc_out,   15);
    chk("t1_beat",        beat_cnt,  1);
    chk("t1_ovf",         ovf,       0);
    handshake();
    chk("t1_post_valid",  out_valid, 0);
    chk("t1_post_ready",  in_ready,  1);

    // Four back-to-back full-scale beats
    in_valid = 1'b1;
    in_a     = 8'd255;
    in_b     = 8'd255;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t2_in_ready_after_last", in_ready, 0);
    tick();
    tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_acc",   acc_out,   260100);
    chk("t2_beat",  beat_cnt,  4);
    chk("t2_ovf",   ovf,       0);
    handshake();

    // Seventeen full-scale beats overflow the 20-bit accumulator
    in_valid = 1'b1;
    in_a     = 8'd255;
    in_b     = 8'd255;
    in_last  = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    tick();
    chk("t3_valid", out_valid, 1);
    chk("t3_acc",   acc_out,   exp17);
    chk("t3_beat",  beat_cnt,  17);
    chk("t3_ovf",   ovf,       1);
    handshake();
    chk("t3_ovf_cleared", ovf, 0);

    // Output back-pressure: result holds while out_ready is low
    send(8'd10, 8'd10, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_acc",   acc_out,   100);
      chk("t4_hold_ready", in_ready,  0);
      tick();
    end
    handshake();
    chk("t4_post_acc",   acc_out,   0);
    chk("t4_post_ready", in_ready,  1);
    chk("t4_post_beat",  beat_cnt,  0);

    // Input bubbles inside a packet
    send(8'd10, 8'd10, 1'b0);
    tick();
    tick();
    tick();
    chk("t5_bubble_ready", in_ready,  1);
    chk("t5_bubble_beat",  beat_cnt,  1);
    chk("t5_bubble_acc",   acc_out,   100);
    send(8'd1, 8'd1, 1'b1);
    tick();
    tick();
    chk("t5_valid", out_valid, 1);
    chk("t5_acc",   acc_out,   101);
    chk("t5_beat",  beat_cnt,  2);
    handshake();

    // Asynchronous reset mid-packet discards in-flight work
    send(8'd7, 8'd7, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    tick();
    chk("t6_pre_acc",  acc_out,  49);
    chk("t6_pre_beat", beat_cnt, 2);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_acc",   acc_out,   0);
    chk("t6_async_beat",  beat_cnt,  0);
    chk("t6_async_ready", in_ready,  1);
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_ovf",   ovf,       0);
    tick();
    rst = 1'b0;
    tick();
    send(8'd2, 8'd2, 1'b1);
    tick();
    tick();
    chk("t6_valid", out_valid, 1);
    chk("t6_acc",   acc_out,   4);
    chk("t6_beat",  beat_cnt,  1);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_accum.md
# mac_accum

Sequential multiply-accumulate front end wrapped around the team's combinational `mult8` array multiplier. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and registers each pair into `mult8`. It registers the 16-bit product, sums the products of one packet (terminated by `in_last`) into a wide accumulator, and presents the packet's sum on a valid/ready output port.

## Interface
- `N`, 8, operand width; must match `mult8`
- `ACC_W`, 20, accumulator width; 16 beats of full-scale products fit without overflow
- `CNT_W`, 8, beat-counter width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept a pair
- `in_a`  in  N  unsigned operand A
- `in_b`  in  N  unsigned operand B
- `in_last`  in  1  final pair of the packet
- `out_valid`  out  1  packet sum valid
- `out_ready`  in  1  consumer accepts the sum
- `acc_out`  out  ACC_W  packet sum
- `beat_cnt`  out  CNT_W  pairs accepted in the current packet; wraps modulo 2^CNT_W
- `ovf`  out  1  sticky: an accumulation exceeded ACC_W bits in this packet

## Operation
- A beat is accepted at a rising edge with `in_valid && in_ready`.
- Pipeline:
  - S1: `a_r`, `b_r`, `last1`, `v1` load on accept.
  - `mult8(a_r, b_r)` feeds S2, where `prod_r[2N-1:0]`, `last2` and `v2` load unconditionally.
  - S3: when `v2`, the accumulator loads `acc + zero_ext(prod_r)`.
- The pipeline never stalls. Back-pressure is applied only at `in_ready`.
- FSM states (encoding in package):
  - IDLE: acc = 0, `in_ready` = 1. Accept without last goes to RUN. Accept with last goes to FLUSH.
  - RUN: `in_ready` = 1. Accept with last goes to FLUSH.
  - FLUSH: `in_ready` = 0. When `v2 && last2` (the final add occurs this edge), goes to DONE.
  - DONE: `out_valid` = 1, `in_ready` = 0. On `out_ready` goes to IDLE; acc, `beat_cnt` and `ovf` clear at that edge.
- `beat_cnt` increments on every accept.
- `ovf` is set when the carry-out of the (ACC_W+1)-bit add is 1. It stays set until the DONE handshake or reset.
- `in_valid` bubbles are allowed in RUN; state and acc are unaffected.
- `in_a`, `in_b` and `in_last` are ignored when `in_ready` = 0.
- Reset mid-operation:
  - Everything clears immediately.
  - In-flight beats are discarded.
  - State goes to IDLE.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `acc_out` = 0
  - `beat_cnt` = 0
  - `ovf` = 0
  - Internal valids = 0
  - State = IDLE
- Last beat accepted at edge k:
  - product registered at k+1
  - accumulated at k+2
  - `out_valid` = 1 from edge k+2
- Latency from last accept to result is 2 cycles.
- `acc_out`, `beat_cnt` and `ovf` are driven directly from registers. They hold stable while `out_valid && !out_ready`.
- After the output handshake at edge m, `in_ready` = 1 and `acc_out` = 0 from edge m.
- Back-to-back throughput is 1 pair per cycle within a packet. The inter-packet gap is at least 3 cycles plus output wait.
- A single-beat packet goes IDLE → FLUSH → DONE.

## Configuration
- `MAC_SAT_EN`:
  - Defined: on carry-out, acc loads all-ones (2^ACC_W−1) and stays there. Later adds cannot leave saturation; `ovf` = 1.
  - Undefined: acc wraps modulo 2^ACC_W; `ovf` is still set.

## Structure
- Package `mac_pkg`:
  - state enum (IDLE, RUN, FLUSH, DONE)
  - `MAC_N` = 8
  - `MAC_ACC_W` = 20
  - `MAC_CNT_W` = 8
  - product width `2*MAC_N`
- One sub-module: existing `mult8` (parameter N), instantiated once between S1 and S2.
- FSM, pipeline registers and accumulator live in `mac_accum`.

## Test plan
- Single beat a=3, b=5, last=1 → `out_valid` 2 cycles after accept; `acc_out` = 15, `beat_cnt` = 1, `ovf` = 0.
- Four back-to-back beats 255×255, last on 4th → `acc_out` = 260100, `beat_cnt` = 4, `in_ready` = 0 from the cycle after the last accept.
- 17 beats 255×255:
  - without `MAC_SAT_EN` → `acc_out` = 56849, `ovf` = 1.
  - with `MAC_SAT_EN` → `acc_out` = 1048575, `ovf` = 1.
- Hold `out_ready` = 0 for 5 cycles after a=10, b=10, last → `acc_out` = 100 stable, `in_ready` = 0. After the handshake, `acc_out` = 0, `in_ready` = 1, `beat_cnt` = 0.
- Beats a=10, b=10, then 3 idle cycles, then a=1, b=1 with last → `acc_out` = 101, `beat_cnt` = 2.
- Assert `rst` mid-cycle after 2 accepted beats → all outputs reset asynchronously. After release, send a=2, b=2, last → `acc_out` = 4, `beat_cnt` = 1.
